// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: operation codes, FSM states and
// per-operation decode helpers.
package mem_access_pkg;

    localparam int OPT_W = 8;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [OPT_W-1:0] OptNop = 8'h00;
    localparam logic [OPT_W-1:0] OptAdd = 8'h01;
    localparam logic [OPT_W-1:0] OptLb  = 8'h20;
    localparam logic [OPT_W-1:0] OptLh  = 8'h21;
    localparam logic [OPT_W-1:0] OptLw  = 8'h22;
    localparam logic [OPT_W-1:0] OptLbu = 8'h24;
    localparam logic [OPT_W-1:0] OptLhu = 8'h25;
    localparam logic [OPT_W-1:0] OptSb  = 8'h28;
    localparam logic [OPT_W-1:0] OptSh  = 8'h29;
    localparam logic [OPT_W-1:0] OptSw  = 8'h2A;

    typedef enum logic [1:0] {
        MemIdle   = 2'd0,
        MemAccess = 2'd1,
        MemDone   = 2'd2
    } mem_state_e;

    function automatic logic opt_is_store(input logic [OPT_W-1:0] opt);
        return (opt == OptSb) || (opt == OptSh) || (opt == OptSw);
    endfunction

    function automatic logic opt_is_mem(input logic [OPT_W-1:0] opt);
        return opt_is_store(opt) || (opt == OptLb) || (opt == OptLh) ||
               (opt == OptLw) || (opt == OptLbu) || (opt == OptLhu);
    endfunction

    // Index of the final byte of the transfer (byte count minus one).
    function automatic logic [1:0] opt_last_idx(input logic [OPT_W-1:0] opt);
        logic [1:0] idx;
        idx = 2'd0;
        if ((opt == OptLh) || (opt == OptLhu) || (opt == OptSh)) idx = 2'd1;
        if ((opt == OptLw) || (opt == OptSw))                    idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of the assembled load buffer according to the load type.
module mem_access_load_ext
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OPT_W-1:0] opt_i,
    input  logic [XLEN-1:0]  buf_i,
    output logic [XLEN-1:0]  wdata_o
);

    always_comb begin
        wdata_o = '0;
        case (opt_i)
            OptLb:   wdata_o = {{(XLEN-8){buf_i[7]}}, buf_i[7:0]};
            OptLbu:  wdata_o = {{(XLEN-8){1'b0}}, buf_i[7:0]};
            OptLh:   wdata_o = {{(XLEN-16){buf_i[15]}}, buf_i[15:0]};
            OptLhu:  wdata_o = {{(XLEN-16){1'b0}}, buf_i[15:0]};
            OptLw:   wdata_o = buf_i;
            default: wdata_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through and runs byte-serial
// load/store transfers over the byte-wide memory-controller port.
//
// state     | meaning
// MemIdle   | pass-through; a memory op latches its operands and stalls
// MemAccess | one byte per ack, byte index k counts up to count-1
// MemDone   | one cycle: stall released, load result presented
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPT_W-1:0]  opt_i,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   rdata2_i,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i
);

    mem_state_e        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [OPT_W-1:0]  opt_q, opt_d;
    logic [XLEN-1:0]   ext_data;

    mem_access_load_ext #(.XLEN(XLEN)) u_load_ext (
        .opt_i   (opt_q),
        .buf_i   (buf_q),
        .wdata_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MemIdle;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            buf_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            opt_q   <= OptNop;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            opt_q   <= opt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        opt_d       = opt_q;
        we_o        = 1'b0;
        waddr_o     = 5'd0;
        wdata_o     = '0;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;

        case (state_q)
            MemIdle: begin
                if (opt_is_mem(opt_i)) begin
                    stall_o = 1'b1;
                    addr_d  = ADDR_W'(alu_i);
                    sdata_d = rdata2_i;
                    opt_d   = opt_i;
                    last_d  = opt_last_idx(opt_i);
                    k_d     = 2'd0;
                    buf_d   = '0;
                    state_d = MemAccess;
                end else begin
                    we_o    = we_i;
                    waddr_o = waddr_i;
                    wdata_o = alu_i;
                end
            end
            MemAccess: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = opt_is_store(opt_q);
                mem_addr_o  = addr_q + ADDR_W'(k_q);
                mem_wdata_o = sdata_q[{k_q, 3'b000} +: 8];
                if (mem_ack_i) begin
                    if (!opt_is_store(opt_q)) buf_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
                    if (k_q == last_q) state_d = MemDone;
                    else               k_d     = k_q + 2'd1;
                end
            end
            MemDone: begin
                we_o    = opt_is_store(opt_q) ? 1'b0 : we_i;
                waddr_o = waddr_i;
                wdata_o = ext_data;
                state_d = MemIdle;
            end
            default: state_d = MemIdle;
        endcase

        // Reset wins combinationally so a request is withdrawn in the same cycle.
        if (rst) begin
            we_o        = 1'b0;
            waddr_o     = 5'd0;
            wdata_o     = '0;
            stall_o     = 1'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a behavioural byte-memory responder with a
// scoreboard of expected byte requests and expected writeback results.
module tb_mem_access;
    import mem_access_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [OPT_W-1:0]  opt_i;
    logic              we_i;
    logic [4:0]        waddr_i;
    logic [31:0]       alu_i;
    logic [31:0]       rdata2_i;
    logic              we_o;
    logic [4:0]        waddr_o;
    logic [31:0]       wdata_o;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;
    logic              mem_ack_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  rd;
    } req_t;

    typedef struct {
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wa;
        bit          chk_data;
        int          stalls;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .opt_i       (opt_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .alu_i       (alu_i),
        .rdata2_i    (rdata2_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op, answer byte requests after `delay` wait cycles, check the
    // result in the cycle the stall drops. abort_after>0 returns after that many acks.
    task automatic run_op(input logic [7:0] opt, input logic we, input logic [4:0] wa,
                          input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [31:0] rbytes, input int n, input logic st,
                          input int delay, input logic [31:0] exp_wd, input logic exp_we,
                          input int exp_stalls, input bit chk_data, input int abort_after);
        int   stalls;
        int   waitc;
        int   acks;
        bit   done;
        res_t r;
        @(posedge clk); #1;
        opt_i = opt; we_i = we; waddr_i = wa; alu_i = alu; rdata2_i = rd2;
        mem_ack_i = 1'b0;
        for (int i = 0; i < n; i++)
            req_q.push_back('{addr: alu + 32'(i), we: st, wd: rd2[8*i +: 8], rd: rbytes[8*i +: 8]});
        res_q.push_back('{wd: exp_wd, we: exp_we, wa: wa, chk_data: chk_data, stalls: exp_stalls});
        stalls = 0; waitc = 0; acks = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (stall_o) stalls++;
            if (mem_req_o) begin
                if (req_q.size() == 0) begin
                    chk("extra_req", {31'b0, mem_req_o}, 32'd0);
                    done = 1'b1;
                end else begin
                    chk("mem_addr", mem_addr_o, req_q[0].addr);
                    chk("mem_we", {31'b0, mem_we_o}, {31'b0, req_q[0].we});
                    if (req_q[0].we) chk("mem_wdata", {24'b0, mem_wdata_o}, {24'b0, req_q[0].wd});
                    if (waitc == delay) begin
                        mem_ack_i = 1'b1;
                        mem_rdata_i = req_q[0].rd;
                        void'(req_q.pop_front());
                        waitc = 0;
                        acks++;
                    end else begin
                        waitc++;
                    end
                end
            end else if (!stall_o) begin
                r = res_q.pop_front();
                if (r.chk_data) chk("wdata", wdata_o, r.wd);
                chk("we", {31'b0, we_o}, {31'b0, r.we});
                if (r.we) chk("waddr", {27'b0, waddr_o}, {27'b0, r.wa});
                chk("stall_cycles", stalls, r.stalls);
                chk("bytes_left", req_q.size(), 0);
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
                mem_ack_i = 1'b0;
                mem_rdata_i = 8'h00;
                if (abort_after > 0 && acks == abort_after) return;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL timeout observed=not_done expected=done");
        end
        @(posedge clk); #1;
        opt_i = OptNop; we_i = 1'b0;
        #1;
        chk("idle_req", {31'b0, mem_req_o}, 32'd0);
        chk("idle_stall", {31'b0, stall_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        opt_i = OptAdd; we_i = 1'b1; waddr_i = 5'd5; alu_i = 32'h55; rdata2_i = 32'hFFFF_FFFF;
        mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_we", {31'b0, we_o}, 32'd0);
        chk("rst_waddr", {27'b0, waddr_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", {24'b0, mem_wdata_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; opt_i = OptNop; we_i = 1'b0;

        // ALU pass-through
        run_op(OptAdd, 1'b1, 5'd5, 32'h55, 32'h0, 32'h0, 0, 1'b0, 0, 32'h55, 1'b1, 0, 1'b1, 0);
        // LW little-endian
        run_op(OptLw, 1'b1, 5'd7, 32'h1000, 32'h0, 32'h1234_5678, 4, 1'b0, 0,
               32'h1234_5678, 1'b1, 5, 1'b1, 0);
        // byte / half extension
        run_op(OptLb, 1'b1, 5'd8, 32'h1100, 32'h0, 32'h0000_0080, 1, 1'b0, 0,
               32'hFFFF_FF80, 1'b1, 2, 1'b1, 0);
        run_op(OptLbu, 1'b1, 5'd9, 32'h1101, 32'h0, 32'h0000_0080, 1, 1'b0, 0,
               32'h0000_0080, 1'b1, 2, 1'b1, 0);
        run_op(OptLh, 1'b1, 5'd10, 32'h1200, 32'h0, 32'h0000_8000, 2, 1'b0, 0,
               32'hFFFF_8000, 1'b1, 3, 1'b1, 0);
        run_op(OptLhu, 1'b1, 5'd11, 32'h1300, 32'h0, 32'h0000_8001, 2, 1'b0, 0,
               32'h0000_8001, 1'b1, 3, 1'b1, 0);
        // misaligned store half, we_i high but store must not write back
        run_op(OptSh, 1'b1, 5'd12, 32'h2001, 32'hABCD_1234, 32'h0, 2, 1'b1, 0,
               32'h0, 1'b0, 3, 1'b0, 0);
        // store word with slow acks (ack on third cycle of each byte)
        run_op(OptSw, 1'b0, 5'd0, 32'h3000, 32'hDEAD_BEEF, 32'h0, 4, 1'b1, 2,
               32'h0, 1'b0, 13, 1'b0, 0);
        run_op(OptSb, 1'b0, 5'd0, 32'h3007, 32'h0000_00A5, 32'h0, 1, 1'b1, 1,
               32'h0, 1'b0, 3, 1'b0, 0);
        // address wrap
        run_op(OptLh, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 2, 1'b0, 0,
               32'h0000_1234, 1'b1, 3, 1'b1, 0);

        // reset in the middle of a word load
        run_op(OptLw, 1'b1, 5'd14, 32'h4000, 32'h0, 32'h4433_2211, 4, 1'b0, 0,
               32'h4433_2211, 1'b1, 5, 1'b1, 2);
        rst = 1'b1;
        #1;
        chk("abort_req", {31'b0, mem_req_o}, 32'd0);
        chk("abort_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; opt_i = OptNop; we_i = 1'b0;
        req_q.delete();
        res_q.delete();
        #1;
        chk("post_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);
        run_op(OptLb, 1'b1, 5'd15, 32'h5000, 32'h0, 32'h0000_007F, 1, 1'b0, 0,
               32'h0000_007F, 1'b1, 2, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits downstream of the ex_mem register and upstream of mem_wb.
- Non-memory results pass straight through.
- For LB/LH/LW/LBU/LHU/SB/SH/SW it runs a byte-serial transfer over the byte-wide memory-controller port. It stalls the pipeline until the transfer completes.
- Load data is sign- or zero-extended before it goes to writeback.

Parameters:
- ADDR_W, 32, width of the address bus and of alu_i/mem_addr_o.
- XLEN, 32, register and data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- opt_i  in  OptBus  operation code from ex_mem.
- we_i  in  1  register write enable from ex_mem.
- waddr_i  in  5  destination register from ex_mem.
- alu_i  in  XLEN  ALU result or effective address.
- rdata2_i  in  XLEN  store data.
- we_o  out  1  write enable to mem_wb.
- waddr_o  out  5  destination register to mem_wb.
- wdata_o  out  XLEN  writeback data to mem_wb.
- stall_o  out  1  stall request to pipeline control.
- mem_req_o  out  1  byte request to the memory controller.
- mem_we_o  out  1  1 = write byte, 0 = read byte.
- mem_addr_o  out  ADDR_W  byte address.
- mem_wdata_o  out  8  byte to write.
- mem_rdata_i  in  8  read byte; valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  current byte accepted (write) or returned (read).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state returns to IDLE; byte index and data buffer clear.
  - While rst=1 all outputs are forced to 0: we_o, waddr_o, wdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o.
- Byte count per op:
  - LB, LBU, SB: 1.
  - LH, LHU, SH: 2.
  - LW, SW: 4.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Non-memory opt: we_o=we_i, waddr_o=waddr_i, wdata_o=alu_i, stall_o=0. Stays in IDLE.
  - Memory opt: stall_o=1 and mem_req_o=0. Latches the address (alu_i), store data (rdata2_i), the byte count, and signed/unsigned. Clears byte index k. Goes to ACCESS.
- ACCESS:
  - Drives stall_o=1 and mem_req_o=1.
  - mem_we_o = 1 for stores, 0 for loads.
  - mem_addr_o = latched address + k, 32-bit modulo (wraps past 0xFFFFFFFF to 0).
  - mem_wdata_o = store_data[8k+7:8k].
  - Outputs stay stable until mem_ack_i=1. There is no timeout.
  - On ack of a load, capture mem_rdata_i into buffer byte k.
  - On ack, if k = count-1 go to DONE; otherwise k <= k+1.
- DONE (one cycle):
  - stall_o=0, so the pipeline advances this cycle.
  - Loads: we_o=we_i, waddr_o=waddr_i.
  - Stores: we_o=0.
  - LB/LH: wdata_o = buffer sign-extended from bit 7/15.
  - LBU/LHU: zero-extended.
  - LW: full word. Little-endian (byte 0 at the lowest address).
  - Next state IDLE.
- Latency with ack every cycle: 1 IDLE + N ACCESS + 1 DONE. stall_o is high for N+1 cycles (LW: 5).
- Alignment: misaligned addresses need no special handling; bytes are issued individually.
- Control inputs: ex_mem holds its inputs while stall_o=1. Input changes during ACCESS are ignored; only latched values are used.
- Reset mid-transfer: mem_req_o drops in the same cycle and the partial transfer is abandoned. The controller must tolerate a withdrawn request.
- Back-to-back memory ops: DONE goes to IDLE, so the next op starts one cycle later. There are no merged transfers.

Decomposition:
- defines.v (shared): Opt* codes for loads/stores, state encodings MemIdle/MemAccess/MemDone, ZeroWord.
- One natural sub-module, load_ext: combinational sign/zero extension of the buffer by opt.

Test Plan:
- LW addr 0x1000, bytes 0x78,0x56,0x34,0x12, ack every cycle -> addrs 0x1000..0x1003 in order, stall_o high 5 cycles, DONE wdata_o=0x12345678, we_o=1.
- LB byte 0x80 -> wdata_o=0xFFFFFF80; LBU byte 0x80 -> wdata_o=0x00000080; LH bytes 0x00,0x80 -> 0xFFFF8000.
- SH addr 0x2001, rdata2=0xABCD1234 -> write 0x34@0x2001 then 0x12@0x2002 with mem_we_o=1; DONE we_o=0; no third request.
- ADD alu_i=0x55, we_i=1, waddr_i=5 -> same cycle wdata_o=0x55, we_o=1, waddr_o=5, stall_o=0, mem_req_o=0.
- SW with ack delayed 3 cycles per byte -> addr/data held stable through each wait; stall_o high 13 cycles, then DONE.
- LH addr 0xFFFFFFFF -> second byte address 0x00000000.
- LW with rst asserted after 2 acks -> mem_req_o=0 that cycle; IDLE afterwards; a following LB completes normally.
